instr_decode_ctrl: RTL and testbench

INSTR_DECODE_CTRL -- requirements
Module: instr_decode_ctrl

---
 rtl/ctrl_pkg.sv | 90 +++++++++
 rtl/instr_decode_ctrl_call_stack.sv | 54 +++++
 rtl/instr_decode_ctrl.sv | 165 ++++++++++++++++
 tb/tb_instr_decode_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the instruction decode controller.
// Opcode, ALU-op and FSM state enums plus the static decode table.
package ctrl_pkg;

  localparam int STACK_DEPTH_DEF = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_LDI  = 4'h6,
    OP_CMP  = 4'h7,
    OP_JMP  = 4'h8,
    OP_JZ   = 4'h9,
    OP_JNZ  = 4'hA,
    OP_JC   = 4'hB,
    OP_CALL = 4'hC,
    OP_RET  = 4'hD,
    OP_RSVD = 4'hE,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic    reg_we;
    logic    src_imm;
    logic    load_imm;
    alu_op_e alu_op;
    logic    flag_ld;
  } dec_t;

  function automatic dec_t decode(opcode_e op);
    dec_t d;
    d = '{reg_we: 1'b0, src_imm: 1'b0,
          load_imm: 1'b0, alu_op: ALU_ADD,
          flag_ld: 1'b0};
    unique case (op)
      OP_ADD: begin
        d.reg_we  = 1'b1;
        d.flag_ld = 1'b1;
      end
      OP_SUB: begin
        d.reg_we  = 1'b1;
        d.alu_op  = ALU_SUB;
        d.flag_ld = 1'b1;
      end
      OP_AND: begin
        d.reg_we  = 1'b1;
        d.alu_op  = ALU_AND;
        d.flag_ld = 1'b1;
      end
      OP_OR: begin
        d.reg_we  = 1'b1;
        d.alu_op  = ALU_OR;
        d.flag_ld = 1'b1;
      end
      OP_ADDI: begin
        d.reg_we  = 1'b1;
        d.src_imm = 1'b1;
        d.flag_ld = 1'b1;
      end
      OP_LDI: begin
        d.reg_we   = 1'b1;
        d.src_imm  = 1'b1;
        d.load_imm = 1'b1;
      end
      OP_CMP: begin
        d.alu_op  = ALU_SUB;
        d.flag_ld = 1'b1;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instr_decode_ctrl_call_stack.sv
// LIFO of 8-bit return addresses for CALL/RET.
// Push when full and pop when empty are ignored here; the caller flags them.
module call_stack
  import ctrl_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH_DEF
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] top,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   sp_q;
  logic [AW:0]   sp_d;
  logic [AW-1:0] top_idx;
  logic [7:0]    mem_q [DEPTH];

  assign full    = (sp_q == (AW+1)'(DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = AW'(sp_q - 1'b1);
  assign top     = mem_q[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (push && !full) begin
      sp_d = sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_d = sp_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entries need no reset; only sp decides what is live.
  always_ff @(posedge CLK) begin
    if (!reset && push && !full) begin
      mem_q[sp_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/instr_decode_ctrl.sv
// Decode/control for the 24-bit ISA: RUN/HALT FSM, flags, PC select.
// Define CALL_STACK_EN to build the hardware call stack.
module instr_decode_ctrl
  import ctrl_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [23:0] instr,
  input  logic [7:0]  pc,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        resume,
  output logic [3:0]  rd_addr,
  output logic [3:0]  rs_addr,
  output logic [3:0]  rt_addr,
  output logic        reg_we,
  output logic        alu_src_imm,
  output logic        load_imm,
  output logic [1:0]  alu_op,
  output logic [7:0]  immediate,
  output logic        PCSrc,
  output logic        flag_z,
  output logic        flag_c,
  output logic        halted,
  output logic        stack_err
);

  opcode_e    op;
  logic [7:0] imm;
  dec_t       dec;
  logic       flag_ld;
  state_e     state_q;
  state_e     state_d;
  logic       flag_z_q;
  logic       flag_c_q;

  assign op      = opcode_e'(instr[23:20]);
  assign rd_addr = instr[19:16];
  assign rs_addr = instr[15:12];
  assign rt_addr = instr[11:8];
  assign imm     = instr[7:0];

  assign flag_z = flag_z_q;
  assign flag_c = flag_c_q;
  assign halted = (state_q == HALT);

`ifdef CALL_STACK_EN
  logic       push;
  logic       pop;
  logic       err_set;
  logic       stk_full;
  logic       stk_empty;
  logic [7:0] stk_top;
  logic       stack_err_q;

  call_stack #(
    .DEPTH (STACK_DEPTH)
  ) u_call_stack (
    .CLK   (CLK),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc + 8'd1),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign stack_err = stack_err_q;
`else
  logic unused_depth;

  assign unused_depth = (STACK_DEPTH > 1);
  assign stack_err    = 1'b0;
`endif

  always_comb begin
    dec         = decode(op);
    reg_we      = 1'b0;
    alu_src_imm = 1'b0;
    load_imm    = 1'b0;
    alu_op      = ALU_ADD;
    flag_ld     = 1'b0;
    PCSrc       = 1'b0;
    immediate   = imm;
    state_d     = state_q;
`ifdef CALL_STACK_EN
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
`endif
    if (state_q == HALT) begin
      // Re-select pc so fetch stays put until resume.
      if (resume) begin
        state_d = RUN;
      end else begin
        PCSrc     = 1'b1;
        immediate = pc;
      end
    end else begin
      reg_we      = dec.reg_we;
      alu_src_imm = dec.src_imm;
      load_imm    = dec.load_imm;
      alu_op      = dec.alu_op;
      flag_ld     = dec.flag_ld;
      unique case (op)
        OP_JMP: PCSrc = 1'b1;
        OP_JZ:  PCSrc = flag_z_q;
        OP_JNZ: PCSrc = !flag_z_q;
        OP_JC:  PCSrc = flag_c_q;
        OP_CALL: begin
          PCSrc = 1'b1;
`ifdef CALL_STACK_EN
          push    = !stk_full;
          err_set = stk_full;
`endif
        end
        OP_RET: begin
`ifdef CALL_STACK_EN
          if (stk_empty) begin
            err_set = 1'b1;
          end else begin
            PCSrc     = 1'b1;
            immediate = stk_top;
            pop       = 1'b1;
          end
`endif
        end
        OP_HALT: begin
          PCSrc     = 1'b1;
          immediate = pc;
          state_d   = HALT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q  <= RUN;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flag_ld) begin
        flag_z_q <= alu_zero;
        flag_c_q <= alu_carry;
      end
    end
  end

`ifdef CALL_STACK_EN
  always_ff @(posedge CLK) begin
    if (reset) begin
      stack_err_q <= 1'b0;
    end else if (err_set) begin
      stack_err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Directed bench for instr_decode_ctrl with an expected-value queue.
// Stack cases follow CALL_STACK_EN; otherwise CALL/RET act as JMP/NOP.
module tb_instr_decode_ctrl;

  logic        CLK = 1'b0;
  logic        reset;
  logic [23:0] instr;
  logic [7:0]  pc;
  logic        alu_zero;
  logic        alu_carry;
  logic        resume;
  logic [3:0]  rd_addr;
  logic [3:0]  rs_addr;
  logic [3:0]  rt_addr;
  logic        reg_we;
  logic        alu_src_imm;
  logic        load_imm;
  logic [1:0]  alu_op;
  logic [7:0]  immediate;
  logic        PCSrc;
  logic        flag_z;
  logic        flag_c;
  logic        halted;
  logic        stack_err;

  typedef struct packed {
    logic       src;
    logic [7:0] imm;
    logic       we;
    logic [1:0] op;
    logic       si;
    logic       li;
    logic       z;
    logic       c;
    logic       h;
    logic       se;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   sn = 0;

`ifdef CALL_STACK_EN
  localparam logic RET_ERR = 1'b1;
`else
  localparam logic RET_ERR = 1'b0;
`endif

  instr_decode_ctrl dut (
    .CLK         (CLK),
    .reset       (reset),
    .instr       (instr),
    .pc          (pc),
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry),
    .resume      (resume),
    .rd_addr     (rd_addr),
    .rs_addr     (rs_addr),
    .rt_addr     (rt_addr),
    .reg_we      (reg_we),
    .alu_src_imm (alu_src_imm),
    .load_imm    (load_imm),
    .alu_op      (alu_op),
    .immediate   (immediate),
    .PCSrc       (PCSrc),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .halted      (halted),
    .stack_err   (stack_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL s%0d %s: got %h expected %h", sn, tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs just after the edge, check before the next.
  task automatic step(
    input logic rst, input logic [23:0] ins, input logic [7:0] p,
    input logic az, input logic ac, input logic rs,
    input logic e_src, input logic [7:0] e_imm, input logic e_we,
    input logic [1:0] e_op, input logic e_si, input logic e_li,
    input logic e_z, input logic e_c, input logic e_h, input logic e_se);
    exp_t e;
    @(posedge CLK);
    #1;
    sn++;
    reset     = rst;
    instr     = ins;
    pc        = p;
    alu_zero  = az;
    alu_carry = ac;
    resume    = rs;
    q.push_back('{src: e_src, imm: e_imm, we: e_we, op: e_op,
                  si: e_si, li: e_li, z: e_z, c: e_c, h: e_h, se: e_se});
    #3;
    e = q.pop_front();
    chk("PCSrc", 8'(PCSrc), 8'(e.src));
    chk("immediate", immediate, e.imm);
    chk("reg_we", 8'(reg_we), 8'(e.we));
    chk("alu_op", 8'(alu_op), 8'(e.op));
    chk("alu_src_imm", 8'(alu_src_imm), 8'(e.si));
    chk("load_imm", 8'(load_imm), 8'(e.li));
    chk("flag_z", 8'(flag_z), 8'(e.z));
    chk("flag_c", 8'(flag_c), 8'(e.c));
    chk("halted", 8'(halted), 8'(e.h));
    chk("stack_err", 8'(stack_err), 8'(e.se));
    chk("rd_addr", 8'(rd_addr), 8'(ins[19:16]));
  endtask

  initial begin
    reset     = 1'b1;
    instr     = '0;
    pc        = '0;
    alu_zero  = 1'b0;
    alu_carry = 1'b0;
    resume    = 1'b0;
    repeat (2) @(posedge CLK);

    // rst ins pc az ac rs | src imm we op si li z c h se
    step(0, 24'h000000, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 24'h123400, 8'h01, 0, 1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 24'hB00010, 8'h02, 0, 0, 0, 1, 8'h10, 0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 24'h100000, 8'h03, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 1, 0, 0);
    step(0, 24'hB00010, 8'h04, 0, 0, 0, 0, 8'h10, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 24'h712000, 8'h05, 1, 0, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 24'h900040, 8'h06, 0, 0, 0, 1, 8'h40, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 24'hA00055, 8'h07, 0, 0, 0, 0, 8'h55, 0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 24'h6300AA, 8'h08, 0, 1, 0, 0, 8'hAA, 1, 0, 1, 1, 1, 0, 0, 0);
    step(0, 24'h510007, 8'h09, 0, 0, 0, 0, 8'h07, 1, 0, 1, 0, 1, 0, 0, 0);
    step(0, 24'h200000, 8'h0A, 1, 1, 0, 0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 24'h300000, 8'h0B, 0, 0, 0, 0, 8'h00, 1, 2, 0, 0, 1, 1, 0, 0);
    step(0, 24'h400000, 8'h0C, 0, 0, 0, 0, 8'h00, 1, 3, 0, 0, 0, 0, 0, 0);
    step(0, 24'h8000C3, 8'h0D, 0, 0, 0, 1, 8'hC3, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 24'hE00011, 8'hC3, 0, 0, 0, 0, 8'h11, 0, 0, 0, 0, 0, 0, 0, 0);
    // HALT, hold while halted, then resume
    step(0, 24'hF00000, 8'h05, 0, 0, 0, 1, 8'h05, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 24'h100000, 8'h05, 1, 1, 0, 1, 8'h05, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 24'h100000, 8'h05, 1, 1, 0, 1, 8'h05, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 24'h000033, 8'h05, 0, 0, 1, 0, 8'h33, 0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 24'h000000, 8'h06, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 24'h000000, 8'h07, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef CALL_STACK_EN
    step(0, 24'hC00080, 8'h03, 0, 0, 0, 1, 8'h80, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 24'hD00000, 8'h80, 0, 0, 0, 1, 8'h04, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 24'hD00000, 8'h04, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 24'h000000, 8'h05, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 24'h000000, 8'h06, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 24'h000000, 8'h07, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    // five CALLs into a depth-4 stack
    for (int i = 0; i < 5; i++) begin
      step(0, 24'hC00080, 8'(8'h10 + i), 0, 0, 0,
           1, 8'h80, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    step(0, 24'h000000, 8'h80, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 24'hD00000, 8'h81, 0, 0, 0, 1, 8'h14, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 24'hD00000, 8'h14, 0, 0, 0, 1, 8'h13, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 24'hD00000, 8'h13, 0, 0, 0, 1, 8'h12, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 24'hD00000, 8'h12, 0, 0, 0, 1, 8'h11, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 24'hD00000, 8'h11, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 24'h000000, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1);
    // return address wraps modulo 256
    step(0, 24'hC00080, 8'hFF, 0, 0, 0, 1, 8'h80, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 24'hD00000, 8'h80, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
`else
    step(0, 24'hC00080, 8'h03, 0, 0, 0, 1, 8'h80, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 24'hD00000, 8'h80, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 24'h000000, 8'h81, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
`endif

    // reset while halted (with resume) and during a CALL
    step(0, 24'h700000, 8'h20, 1, 1, 0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 24'hF00000, 8'h21, 0, 0, 0, 1, 8'h21, 0, 0, 0, 0, 1, 1, 0, 0);
    step(1, 24'h000000, 8'h21, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0, 1, 1, 1, 0);
    step(1, 24'hC00080, 8'h22, 0, 0, 0, 1, 8'h80, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 24'hD00000, 8'h23, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 24'h000000, 8'h24, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0,
         RET_ERR);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
